// File: rtl/erlist_loader.sv
// Byte-stream loader for the Earthrise command list: parses a 16-bit little-endian
// word count, writes payload bytes into erlist lanes, and optionally kicks er_start.
module erlist_loader #(
    parameter int BYTE     = 8,
    parameter int BYTE_CNT = 4,
    parameter int WORD     = BYTE * BYTE_CNT,
    parameter int ADDRW    = 10,
    parameter int LENW     = 16
) (
    input  logic                clk_sys,
    input  logic                rst_sys_n,
    input  logic                load,
    input  logic                auto_start,
    input  logic [ADDRW-1:0]    addr_base,
    input  logic                er_busy,
    input  logic [BYTE-1:0]     s_data,
    input  logic                s_valid,
    output logic                s_ready,
    output logic [BYTE_CNT-1:0] we,
    output logic [ADDRW-1:0]    addr,
    output logic [WORD-1:0]     din,
    output logic                er_start,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int IDXW = (BYTE_CNT > 1) ? $clog2(BYTE_CNT) : 1;
    localparam logic [LENW:0] DEPTH = (LENW+1)'(1) << ADDRW;

    typedef enum logic [2:0] {
        S_IDLE, S_HDR0, S_HDR1, S_DATA, S_DRAIN, S_FIN
    } state_t;

    state_t                state_reg, state_next;
    logic [ADDRW-1:0]      ptr_reg;
    logic [LENW-1:0]       len_reg;
    logic [IDXW-1:0]       idx_reg;
    logic                  auto_reg;
    logic                  err_reg;
    logic [BYTE_CNT-1:0]   we_reg;
    logic [ADDRW-1:0]      addr_reg;
    logic [WORD-1:0]       din_reg;
    logic                  done_reg;
    logic                  start_reg;
    logic                  busy_reg;

    logic                  xfer;
    logic                  last_byte;
    logic                  accept;
    logic [LENW-1:0]       len_hdr;
    logic [LENW:0]         room;
    logic                  len_ovf;
    logic [WORD-1:0]       din_rep;

    assign xfer      = s_valid & s_ready;
    assign last_byte = (idx_reg == IDXW'(BYTE_CNT - 1));
    assign accept    = load & ~er_busy;
    assign len_hdr   = LENW'({s_data, len_reg[BYTE-1:0]});
    // Words left between the base and the top of erlist, one bit wider than len.
    assign room      = DEPTH - {{(LENW+1-ADDRW){1'b0}}, ptr_reg};
    assign len_ovf   = ({1'b0, len_hdr} > room);

    generate
        for (genvar gi = 0; gi < BYTE_CNT; gi++) begin : g_lane
            assign din_rep[gi*BYTE +: BYTE] = s_data;
        end
    endgenerate

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (accept) state_next = S_HDR0;
            S_HDR0:  if (xfer) state_next = S_HDR1;
            S_HDR1: begin
                if (xfer) begin
                    if (len_hdr == '0)  state_next = S_FIN;
                    else if (len_ovf)   state_next = S_DRAIN;
                    else                state_next = S_DATA;
                end
            end
            S_DATA, S_DRAIN: begin
                if (xfer && last_byte && (len_reg == LENW'(1))) state_next = S_FIN;
            end
            S_FIN:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        s_ready = 1'b0;
        case (state_reg)
            S_HDR0, S_HDR1, S_DATA, S_DRAIN: s_ready = 1'b1;
            default:                         s_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            ptr_reg   <= '0;
            len_reg   <= '0;
            idx_reg   <= '0;
            auto_reg  <= 1'b0;
            err_reg   <= 1'b0;
            we_reg    <= '0;
            addr_reg  <= '0;
            din_reg   <= '0;
            done_reg  <= 1'b0;
            start_reg <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            we_reg    <= '0;
            done_reg  <= (state_reg == S_FIN);
            // err is already final in FIN, so the start decision can use it directly.
            start_reg <= (state_reg == S_FIN) & auto_reg & ~err_reg;
            busy_reg  <= (state_next != S_IDLE);
            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        ptr_reg  <= addr_base;
                        auto_reg <= auto_start;
                        err_reg  <= 1'b0;
                        idx_reg  <= '0;
                    end
                end
                S_HDR0: begin
                    if (xfer) len_reg[BYTE-1:0] <= s_data;
                end
                S_HDR1: begin
                    if (xfer) begin
                        len_reg <= len_hdr;
                        idx_reg <= '0;
                        if ((len_hdr != '0) && len_ovf) err_reg <= 1'b1;
                    end
                end
                S_DATA, S_DRAIN: begin
                    if (xfer) begin
                        if (state_reg == S_DATA) begin
                            we_reg   <= BYTE_CNT'(1) << idx_reg;
                            addr_reg <= ptr_reg;
                            din_reg  <= din_rep;
                        end
                        if (last_byte) begin
                            idx_reg <= '0;
                            len_reg <= len_reg - LENW'(1);
                            if (state_reg == S_DATA) ptr_reg <= ptr_reg + ADDRW'(1);
                        end else begin
                            idx_reg <= idx_reg + IDXW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign we       = we_reg;
    assign addr     = addr_reg;
    assign din      = din_reg;
    assign er_start = start_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;
    assign err      = err_reg;

endmodule

// File: tb/tb_erlist_loader.sv
// Randomized bench for erlist_loader: a stream-level model predicts every erlist
// write, the done/er_start timing and err, and a byte-lane erlist model is compared.
module tb_erlist_loader;

    logic        clk_sys = 1'b0;
    logic        rst_sys_n = 1'b0;
    logic        load = 1'b0;
    logic        auto_start = 1'b0;
    logic [9:0]  addr_base = '0;
    logic        er_busy = 1'b0;
    logic [7:0]  s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [3:0]  we;
    logic [9:0]  addr;
    logic [31:0] din;
    logic        er_start;
    logic        busy;
    logic        done;
    logic        err;

    erlist_loader dut (
        .clk_sys    (clk_sys),
        .rst_sys_n  (rst_sys_n),
        .load       (load),
        .auto_start (auto_start),
        .addr_base  (addr_base),
        .er_busy    (er_busy),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .we         (we),
        .addr       (addr),
        .din        (din),
        .er_start   (er_start),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        int          cyc;
        logic [3:0]  we;
        logic [9:0]  addr;
        logic [31:0] din;
    } wr_t;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          start_cnt = 0;
    int          last_done_cyc = 0;
    logic        done_start = 1'b0;
    wr_t         exp_q[$];
    logic [7:0]  stim_q[$];
    logic [31:0] mem_model [0:1023];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // cyc names the posedge just taken; outputs are read on the following negedge.
    always @(posedge clk_sys) cyc <= cyc + 1;

    always @(negedge clk_sys) begin
        if (rst_sys_n) begin
            if (we != 4'b0000) begin
                if (exp_q.size() == 0) begin
                    check("spurious_we", {28'b0, we}, 32'h0);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("wr_cycle", cyc, e.cyc);
                    check("wr_we", {28'b0, we}, {28'b0, e.we});
                    check("wr_addr", {22'b0, addr}, {22'b0, e.addr});
                    check("wr_din", din, e.din);
                end
                for (int l = 0; l < 4; l++)
                    if (we[l]) mem_model[addr][l*8 +: 8] = din[l*8 +: 8];
            end
            if (done) begin
                done_cnt++;
                last_done_cyc = cyc;
                done_start = er_start;
            end
            if (er_start) start_cnt++;
        end
    end

    // Presents one byte and returns the posedge number on which it transferred.
    task automatic send_byte(input logic [7:0] b, input int gap, input bit is_wr,
                             input logic [3:0] ew, input logic [9:0] ea, output int edge_n);
        int t;
        t = 0;
        edge_n = -1;
        while (gap > 0 && $urandom_range(99) < gap) begin
            s_valid = 1'b0;
            s_data  = 8'($urandom);
            @(negedge clk_sys);
        end
        s_data  = b;
        s_valid = 1'b1;
        forever begin
            #1;
            if (s_ready) begin
                edge_n = cyc + 1;
                if (is_wr) exp_q.push_back('{edge_n, ew, ea, {4{b}}});
                @(negedge clk_sys);
                s_valid = 1'b0;
                break;
            end
            t++;
            if (t > 40) begin
                check("s_ready_timeout", {31'b0, s_ready}, 32'h1);
                s_valid = 1'b0;
                break;
            end
            @(negedge clk_sys);
        end
    endtask

    // Runs one load over stim_q (2 header bytes + payload) and checks the outcome.
    task automatic run_load(input logic [9:0] base, input bit auto, input int gap,
                            input int reload_at, input int abort_after);
        int  len, ovf, d0, s0, edge_n, last_edge, k, widx;
        bit  got_done, ok_start;
        len = {24'b0, stim_q[1], stim_q[0]};
        ovf = (len > 0 && len > 1024 - int'(base)) ? 1 : 0;
        ok_start = auto && (ovf == 0);
        d0 = done_cnt;
        s0 = start_cnt;
        last_edge = 0;
        @(negedge clk_sys);
        load = 1'b1; addr_base = base; auto_start = auto;
        @(negedge clk_sys);
        load = 1'b0; addr_base = 10'($urandom); auto_start = 1'($urandom);
        check("busy_acc", {31'b0, busy}, 32'h1);
        check("err_clr", {31'b0, err}, 32'h0);
        for (k = 0; k < stim_q.size(); k++) begin
            bit is_wr;
            is_wr = (k >= 2) && (ovf == 0);
            widx = k - 2;
            if (k == reload_at) begin
                load = 1'b1;
                addr_base = base ^ 10'h155;
            end
            send_byte(stim_q[k], gap, is_wr, 4'(1 << (widx & 3)),
                      10'(int'(base) + (widx >> 2)), edge_n);
            load = 1'b0;
            last_edge = edge_n;
            if (k == 1) check("err_hdr", {31'b0, err}, {31'b0, ovf[0]});
            if (abort_after >= 0 && k == 1 + abort_after) begin
                #2 rst_sys_n = 1'b0;
                #1;
                check("rst_async_we", {28'b0, we}, 32'h0);
                check("rst_async_ctl", {29'b0, s_ready, busy, done}, 32'h0);
                exp_q.delete();
                @(negedge clk_sys);
                rst_sys_n = 1'b1;
                return;
            end
        end
        got_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_sys);
            #3;
            if (done_cnt != d0) begin
                got_done = 1'b1;
                break;
            end
        end
        check("done_seen", {31'b0, got_done}, 32'h1);
        check("done_cycle", last_done_cyc, last_edge + 1);
        check("start_at_done", {31'b0, done_start}, {31'b0, ok_start});
        repeat (3) @(negedge clk_sys);
        check("done_once", done_cnt - d0, 1);
        check("start_count", start_cnt - s0, ok_start ? 1 : 0);
        check("busy_end", {31'b0, busy}, 32'h0);
        check("err_end", {31'b0, err}, {31'b0, ovf[0]});
        check("wr_pending", exp_q.size(), 0);
        if (ovf == 0) begin
            for (int w = 0; w < len; w++) begin
                logic [31:0] ew;
                for (int j = 0; j < 4; j++) ew[j*8 +: 8] = stim_q[2 + 4*w + j];
                check("mem_word", mem_model[10'(int'(base) + w)], ew);
            end
        end
    endtask

    task automatic make_stim(input int len, input int nbytes);
        stim_q.delete();
        stim_q.push_back(8'(len));
        stim_q.push_back(8'(len >> 8));
        for (int i = 0; i < nbytes; i++) stim_q.push_back(8'($urandom));
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem_model[i] = '0;
        repeat (3) @(negedge clk_sys);
        #1;
        check("rst_ctl", {24'b0, we, er_start, done, err, busy}, 32'h0);
        check("rst_ready", {31'b0, s_ready}, 32'h0);
        check("rst_addr_din", {22'b0, addr} | din, 32'h0);
        @(negedge clk_sys);
        rst_sys_n = 1'b1;

        // Basic two-word load with auto start.
        stim_q = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        run_load(10'd0, 1'b1, 0, -1, -1);
        check("basic_w0", mem_model[0], 32'h44332211);
        check("basic_w1", mem_model[1], 32'h88776655);

        // Same payload, gapped stream, different base.
        run_load(10'd8, 1'b1, 50, -1, -1);
        check("gap_w0", mem_model[8], 32'h44332211);
        check("gap_w1", mem_model[9], 32'h88776655);

        // Zero length.
        stim_q = '{8'h00, 8'h00};
        run_load(10'd5, 1'b0, 0, -1, -1);

        // Overflow: 5 words from 1020 does not fit; 20 filler bytes are drained.
        make_stim(5, 20);
        run_load(10'd1020, 1'b1, 20, -1, -1);

        // Blocked load while Earthrise is busy leaves everything untouched.
        er_busy = 1'b1;
        @(negedge clk_sys);
        load = 1'b1; addr_base = 10'd50;
        @(negedge clk_sys);
        load = 1'b0;
        @(negedge clk_sys);
        check("blk_busy", {31'b0, busy}, 32'h0);
        check("blk_ready", {31'b0, s_ready}, 32'h0);
        check("blk_err", {31'b0, err}, 32'h1);
        er_busy = 1'b0;

        // Valid load clears err; a second load mid-transfer must not restart.
        make_stim(1, 4);
        run_load(10'd100, 1'b0, 0, -1, -1);
        make_stim(3, 12);
        run_load(10'd200, 1'b1, 30, 5, -1);

        // Reset mid-load after three data bytes, then a fresh one-word load.
        make_stim(2, 8);
        run_load(10'd300, 1'b1, 0, -1, 3);
        make_stim(1, 4);
        run_load(10'd400, 1'b1, 0, -1, -1);

        // Random loads, including bases near the top of erlist.
        for (int r = 0; r < 10; r++) begin
            int rl;
            logic [9:0] rb;
            rl = $urandom_range(0, 5);
            rb = ($urandom_range(0, 2) == 0) ? 10'($urandom_range(1018, 1023))
                                             : 10'($urandom_range(0, 1000));
            make_stim(rl, rl * 4);
            run_load(rb, 1'($urandom), $urandom_range(0, 1) * 40, -1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
